// File: rtl/cronometro_ctrl_pkg.sv
// rtl/cronometro_ctrl_pkg.sv - shared state encoding and digit limits for the stopwatch controller
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int SEC_U_MAX = 9;
    localparam int SEC_D_MAX = 5;
    localparam int MIN_U_MAX = 9;

    localparam int SEC_U_W = 4;
    localparam int SEC_D_W = 3;
    localparam int MIN_U_W = 4;

endpackage

// File: rtl/cronometro_ctrl_if.sv
// rtl/cronometro_ctrl_if.sv - button inputs and display outputs of the stopwatch controller
interface cronometro_ctrl_if;
    import cronometro_pkg::*;

    logic               BTN_SS;
    logic               BTN_ZR;
    logic               BTN_LAP;
    logic [SEC_U_W-1:0] SEC_U;
    logic [SEC_D_W-1:0] SEC_D;
    logic [MIN_U_W-1:0] MIN_U;
    logic               RUNNING;
    logic               TICK;
    logic               CLK_OUT;
    logic               LAP;

    modport slave (
        input  BTN_SS, BTN_ZR, BTN_LAP,
        output SEC_U, SEC_D, MIN_U, RUNNING, TICK, CLK_OUT, LAP
    );

    modport master (
        output BTN_SS, BTN_ZR, BTN_LAP,
        input  SEC_U, SEC_D, MIN_U, RUNNING, TICK, CLK_OUT, LAP
    );

endinterface

// File: rtl/cronometro_ctrl_bcd_digit_cnt.sv
// rtl/cronometro_ctrl_bcd_digit_cnt.sv - one decimal digit counting 0..MAX with carry out
module bcd_digit_cnt #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         clear,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] QMAX = W'(MAX);

    assign carry = enable && (q == QMAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (enable) begin
            q <= carry ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// rtl/cronometro_ctrl.sv - stopwatch run/pause/clear FSM, 1 s prescaler and BCD cascade
// Optional lap display hold enabled by defining CRONO_LAP_HOLD_EN.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    cronometro_ctrl_if.slave  bus
);

    localparam int            PW      = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    state_t               state;
    state_t               next_state;
    logic [PW-1:0]        pre;
    logic                 clear_all;
    logic                 term;
    logic                 su_carry;
    logic                 sd_carry;
    logic                 mu_carry;
    logic [SEC_U_W-1:0]   su;
    logic [SEC_D_W-1:0]   sd;
    logic [MIN_U_W-1:0]   mu;
    logic                 tick_q;
    logic                 wrap_q;
    logic                 running_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ZR beats SS outside RUN; inside RUN only SS matters
    always_comb begin
        next_state = state;
        clear_all  = 1'b0;
        case (state)
            IDLE:    if (bus.BTN_SS && !bus.BTN_ZR) next_state = RUN;
            RUN:     if (bus.BTN_SS) next_state = PAUSE;
            PAUSE: begin
                if (bus.BTN_ZR) begin
                    next_state = IDLE;
                    clear_all  = 1'b1;
                end else if (bus.BTN_SS) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign term = (state == RUN) && (pre == PRE_MAX);

    always_ff @(posedge CLK) begin
        if (RST || clear_all) begin
            pre <= '0;
        end else if (state == RUN) begin
            pre <= term ? '0 : pre + 1'b1;
        end
    end

    bcd_digit_cnt #(.MAX(SEC_U_MAX), .W(SEC_U_W)) u_sec_u (
        .clk(CLK), .rst(RST), .enable(term), .clear(clear_all), .q(su), .carry(su_carry)
    );
    bcd_digit_cnt #(.MAX(SEC_D_MAX), .W(SEC_D_W)) u_sec_d (
        .clk(CLK), .rst(RST), .enable(su_carry), .clear(clear_all), .q(sd), .carry(sd_carry)
    );
    bcd_digit_cnt #(.MAX(MIN_U_MAX), .W(MIN_U_W)) u_min_u (
        .clk(CLK), .rst(RST), .enable(sd_carry), .clear(clear_all), .q(mu), .carry(mu_carry)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            tick_q    <= term;
            wrap_q    <= mu_carry;
            running_q <= (next_state == RUN);
        end
    end

    assign bus.TICK    = tick_q;
    assign bus.CLK_OUT = wrap_q;
    assign bus.RUNNING = running_q;

`ifdef CRONO_LAP_HOLD_EN
    logic               hold_q;
    logic [SEC_U_W-1:0] su_h;
    logic [SEC_D_W-1:0] sd_h;
    logic [MIN_U_W-1:0] mu_h;

    // Snapshot is taken from the pre-edge digits so the frozen view matches what was shown
    always_ff @(posedge CLK) begin
        if (RST || clear_all) begin
            hold_q <= 1'b0;
            su_h   <= '0;
            sd_h   <= '0;
            mu_h   <= '0;
        end else if (state == RUN && bus.BTN_LAP) begin
            hold_q <= !hold_q;
            if (!hold_q) begin
                su_h <= su;
                sd_h <= sd;
                mu_h <= mu;
            end
        end
    end

    assign bus.LAP   = hold_q;
    assign bus.SEC_U = hold_q ? su_h : su;
    assign bus.SEC_D = hold_q ? sd_h : sd;
    assign bus.MIN_U = hold_q ? mu_h : mu;
`else
    logic unused_lap;
    assign unused_lap = bus.BTN_LAP;

    assign bus.LAP   = 1'b0;
    assign bus.SEC_U = su;
    assign bus.SEC_D = sd;
    assign bus.MIN_U = mu;
`endif

endmodule

// File: tb/tb_cronometro_ctrl.sv
// tb/tb_cronometro_ctrl.sv - self-checking bench for cronometro_ctrl against a seconds-count model
module tb_cronometro_ctrl;

    localparam int T = 4;
`ifdef CRONO_LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    cronometro_ctrl_if bus ();

    cronometro_ctrl #(.TICKS_PER_SEC(T)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model: elapsed seconds 0..599, partial-second cycle count, mode flags
    bit m_run, m_paused, m_tick, m_wrap, m_hold;
    int m_pre, m_secs, m_hsecs;
    int n_tick, n_wrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ss, input bit zr, input bit lap);
        int  s_old;
        bit  was_run;
        m_tick = 0;
        m_wrap = 0;
        if (rst) begin
            m_run = 0; m_paused = 0; m_pre = 0; m_secs = 0; m_hold = 0; m_hsecs = 0;
            return;
        end
        was_run = m_run;
        s_old   = m_secs;
        if (was_run) begin
            m_pre++;
            if (m_pre == T) begin
                m_pre  = 0;
                m_tick = 1;
                m_secs = (m_secs + 1) % 600;
                m_wrap = (m_secs == 0);
            end
            if (LAP_EN && lap) begin
                if (!m_hold) m_hsecs = s_old;
                m_hold = !m_hold;
            end
            if (ss) begin m_run = 0; m_paused = 1; end
        end else if (m_paused) begin
            if (zr) begin
                m_paused = 0; m_secs = 0; m_pre = 0; m_hold = 0;
            end else if (ss) begin
                m_paused = 0; m_run = 1;
            end
        end else if (ss && !zr) begin
            m_run = 1;
        end
    endtask

    task automatic check_all();
        int shown;
        shown = m_hold ? m_hsecs : m_secs;
        check("sec_u",   32'(bus.SEC_U),   32'(shown % 10));
        check("sec_d",   32'(bus.SEC_D),   32'((shown / 10) % 6));
        check("min_u",   32'(bus.MIN_U),   32'(shown / 60));
        check("running", 32'(bus.RUNNING), 32'(m_run));
        check("tick",    32'(bus.TICK),    32'(m_tick));
        check("clk_out", 32'(bus.CLK_OUT), 32'(m_wrap));
        check("lap",     32'(bus.LAP),     32'(m_hold));
    endtask

    task automatic cycle(input bit rst, input bit ss, input bit zr, input bit lap);
        RST = rst;
        bus.BTN_SS = ss;
        bus.BTN_ZR = zr;
        bus.BTN_LAP = lap;
        @(posedge CLK);
        model_edge(rst, ss, zr, lap);
        #1;
        check_all();
        n_tick += int'(bus.TICK);
        n_wrap += int'(bus.CLK_OUT);
        RST = 0;
        bus.BTN_SS = 0;
        bus.BTN_ZR = 0;
        bus.BTN_LAP = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        int lat;
        bus.BTN_SS = 0;
        bus.BTN_ZR = 0;
        bus.BTN_LAP = 0;

        // Reset
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        check("rst_digits", {bus.MIN_U, bus.SEC_D, bus.SEC_U}, 0);

        // Start, 40 cycles -> 10 ticks, 0:10
        cycle(0, 1, 0, 0);
        check("running_after_press", 32'(bus.RUNNING), 1);
        n_tick = 0;
        idle_cycles(40);
        check("ticks_40", n_tick, 10);
        check("sec_d_40", 32'(bus.SEC_D), 1);
        check("sec_u_40", 32'(bus.SEC_U), 0);

        // Pause mid-second, resume, measure latency to next tick
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle_cycles(20);
        cycle(0, 1, 0, 0);
        lat = 0;
        n_tick = 0;
        while (n_tick == 0 && lat < 20) begin
            cycle(0, 0, 0, 0);
            lat++;
        end
        check("resume_latency", lat, 2);

        // ZR in RUN is ignored
        cycle(0, 0, 1, 0);
        idle_cycles(5);
        check("zr_in_run_sec_u", 32'(bus.SEC_U), 2);

        // Pause then clear
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        check("clear_digits", {bus.MIN_U, bus.SEC_D, bus.SEC_U}, 0);

        // Randomized button activity
        for (int i = 0; i < 400; i++) begin
            cycle(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        // Force PAUSE then IDLE, then 600 s full lap
        if (m_run) cycle(0, 1, 0, 0);
        if (m_paused) cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        n_wrap = 0;
        n_tick = 0;
        idle_cycles(2400);
        check("wrap_count", n_wrap, 1);
        check("tick_count_600", n_tick, 600);
        check("wrap_digits", {bus.MIN_U, bus.SEC_D, bus.SEC_U}, 0);

        // SS+ZR in RUN -> PAUSE with digits kept; in PAUSE -> IDLE
        idle_cycles(13);
        cycle(0, 1, 1, 0);
        check("sszr_run_pause", 32'(bus.RUNNING), 0);
        check("sszr_run_sec_u", 32'(bus.SEC_U), 3);
        idle_cycles(3);
        cycle(0, 1, 1, 0);
        check("sszr_pause_idle", {bus.MIN_U, bus.SEC_D, bus.SEC_U}, 0);
        cycle(0, 1, 1, 0);
        check("sszr_idle_stays", 32'(bus.RUNNING), 0);

        // Lap hold at 0:05
        cycle(0, 1, 0, 0);
        idle_cycles(20);
        cycle(0, 0, 0, 1);
        idle_cycles(20);
        check("lap_sec_u", 32'(bus.SEC_U), LAP_EN ? 5 : 0);
        check("lap_flag", 32'(bus.LAP), 32'(LAP_EN));
        cycle(0, 0, 0, 1);
        check("lap_release_sec_d", 32'(bus.SEC_D), 1);

        // Reset mid-run discards everything
        idle_cycles(3);
        cycle(1, 0, 0, 0);
        check("rst_midrun", {bus.LAP, bus.RUNNING, bus.MIN_U, bus.SEC_D, bus.SEC_U}, 0);
        cycle(0, 1, 0, 0);
        n_tick = 0;
        idle_cycles(T - 1);
        check("rst_partial_lost", n_tick, 0);
        idle_cycles(1);
        check("first_tick_after_rst", n_tick, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
